// File: rtl/spm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spm_ctrl_if
//  Description : Bundle of host-side and datapath-side signals of the SPM
//                sequencing controller.
//                Host side     : start, x_in, y_in -> product, busy, done
//                Datapath side : x_out, y_out, ld, spm_clr <- p_in
//                Modport slave  : the controller.
//                Modport master : the surroundings (host plus SPM datapath).
//  Revision    : 1.0  initial release
// ============================================================================
interface spm_ctrl_if #(
    parameter int WIDTH = 64
) ();
    logic                 start;
    logic [WIDTH-1:0]     x_in;
    logic [WIDTH-1:0]     y_in;
    logic [WIDTH-1:0]     x_out;
    logic [WIDTH-1:0]     y_out;
    logic                 ld;
    logic                 spm_clr;
    logic                 p_in;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, x_in, y_in, p_in,
        input  x_out, y_out, ld, spm_clr, product, busy, done
    );

    modport slave (
        input  start, x_in, y_in, p_in,
        output x_out, y_out, ld, spm_clr, product, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/spm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spm_ctrl
//  Description : Sequencing controller for the serial-parallel multiplier.
//                Accepts a start with two WIDTH-bit operands, loads the
//                operand shift register, clears the SPM core, then collects
//                the 2*WIDTH-bit serial product (LSB first) and pulses done.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - spm_ctrl_if.slave (start/x_in/y_in/p_in in;
//                       x_out/y_out/ld/spm_clr/product/busy/done out)
//  Parameters  : WIDTH - operand width
//                LAT   - cycles from serial operand bit to product bit
//  Revision    : 1.0  initial release
// ============================================================================
module spm_ctrl #(
    parameter int WIDTH = 64,
    parameter int LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    spm_ctrl_if.slave  bus
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(c_PW + LAT + 1);

    // Capture window bounds on the RUN counter (first RUN cycle has cnt=0).
    localparam logic [c_CNT_W-1:0] c_CAP_FIRST = c_CNT_W'(LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CAP_LAST  = c_CNT_W'(LAT + c_PW);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_capture;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [c_PW-1:0]     r_product;
    logic                r_ld;
    logic                r_clr;
    logic                r_busy;
    logic                r_done;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_accept    = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_capture = (r_cnt >= c_CAP_FIRST) && (r_cnt <= c_CAP_LAST);
                if (r_cnt == c_CAP_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Strobes are decoded from the next state
    // so that every output comes straight from a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_product <= '0;
            r_ld      <= 1'b0;
            r_clr     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ld    <= (w_state_nxt == S_LOAD);
            r_clr   <= (w_state_nxt == S_LOAD);
            r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_x       <= bus.x_in;
                r_y       <= bus.y_in;
                r_product <= '0;
            end else if (w_capture) begin
                // Shift in from the top: the first captured bit ends at bit 0.
                r_product <= {bus.p_in, r_product[c_PW-1:1]};
            end

            // Counter is held on the final RUN cycle so it never wraps.
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if ((r_state == S_RUN) && (r_cnt != c_CAP_LAST)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.x_out   = r_x;
    assign bus.y_out   = r_y;
    assign bus.product = r_product;
    assign bus.ld      = r_ld;
    assign bus.spm_clr = r_clr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire
